// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART memory bridge.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RESP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] DEF_CMD_WR   = 8'hA5;
  localparam logic [7:0] DEF_CMD_RD   = 8'h5A;
  localparam logic [7:0] DEF_ACK_BYTE = 8'h06;

  // Request frame length: command byte, address bytes, then data bytes for writes.
  function automatic int frame_bytes(input int addr_w, input int data_w, input logic is_wr);
    return 1 + addr_w / 8 + (is_wr ? data_w / 8 : 0);
  endfunction

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 byte transmitter and receiver sharing one bit period.
module uart_byte_phy
  import uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_busy,
  output logic       o_tx,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_byte_phy: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  logic             r_tx_act;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic [8:0]       r_tx_sh;
  logic             r_tx;
  logic             w_tx_last;

  // Busy drops in the final stop-bit cycle so the next byte starts with no gap.
  assign w_tx_last = r_tx_act && (r_tx_bit == 4'd9) && (r_tx_cnt == '0);
  assign o_tx_busy = r_tx_act && !w_tx_last;
  assign o_tx      = r_tx;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_act <= 1'b0;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx     <= 1'b1;
    end else if (i_tx_start && !o_tx_busy) begin
      r_tx_act <= 1'b1;
      r_tx_cnt <= BIT_LAST;
      r_tx_bit <= '0;
      r_tx_sh  <= {1'b1, i_tx_byte};
      r_tx     <= 1'b0;
    end else if (r_tx_act) begin
      if (r_tx_cnt == '0) begin
        if (r_tx_bit == 4'd9) begin
          r_tx_act <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_tx_bit <= r_tx_bit + 4'd1;
          r_tx_cnt <= BIT_LAST;
          r_tx     <= r_tx_sh[0];
          r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
        end
      end else begin
        r_tx_cnt <= r_tx_cnt - CNT_W'(1);
      end
    end
  end

  rx_state_t        r_rx_state;
  logic             r_rx_s1;
  logic             r_rx_s2;
  logic             r_rx_s3;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_sh;
  logic             r_rx_valid;
  logic [7:0]       r_rx_byte;

  assign o_rx_valid = r_rx_valid;
  assign o_rx_byte  = r_rx_byte;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_byte  <= '0;
    end else begin
      r_rx_s1    <= i_rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_s3    <= r_rx_s2;
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_s2 && r_rx_s3) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (r_rx_cnt == '0) begin
            if (r_rx_s2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DATA;
              r_rx_cnt   <= BIT_LAST;
              r_rx_bit   <= '0;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_cnt <= BIT_LAST;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else r_rx_bit <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == '0) begin
            r_rx_state <= RX_IDLE;
            // A low stop bit is a framing error; the byte is dropped silently.
            if (r_rx_s2) begin
              r_rx_valid <= 1'b1;
              r_rx_byte  <= r_rx_sh;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - CNT_W'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// CPU data-port to UART bridge: each load/store becomes a framed request to a host.
// state     | meaning
// IDLE      | waiting for req_we/req_re
// SEND      | shifting request frame out on tx
// WAIT_RESP | collecting ack or read bytes, timeout running
// DONE      | one-cycle completion, mem_done high
module uart_mem_bridge
  import uart_bridge_pkg::*;
#(
  parameter int         ADDR_W       = 32,
  parameter int         DATA_W       = 32,
  parameter int         CLKS_PER_BIT = 434,
  parameter int         TIMEOUT_CYC  = 1000000,
  parameter logic [7:0] CMD_WR       = DEF_CMD_WR,
  parameter logic [7:0] CMD_RD       = DEF_CMD_RD,
  parameter logic [7:0] ACK_BYTE     = DEF_ACK_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tx,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_we,
  input  logic              req_re,
  output logic              busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic [DATA_W-1:0] rd_data
);

  localparam int FRAME_W = 8 + ADDR_W + DATA_W;
  localparam int BYTE_W  = $clog2(1 + ADDR_W / 8 + DATA_W / 8 + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BYTE_W-1:0] WR_BYTES = BYTE_W'(frame_bytes(ADDR_W, DATA_W, 1'b1));
  localparam logic [BYTE_W-1:0] RD_BYTES = BYTE_W'(frame_bytes(ADDR_W, DATA_W, 1'b0));
  localparam logic [BYTE_W-1:0] RD_RESP  = BYTE_W'(DATA_W / 8);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  generate
    if ((ADDR_W % 8) != 0 || ADDR_W < 8 || ADDR_W > 64) begin : g_bad_addr_w
      $error("uart_mem_bridge: ADDR_W must be a multiple of 8 in 8..64");
    end
    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
      $error("uart_mem_bridge: DATA_W must be a multiple of 8 in 8..64");
    end
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
      $error("uart_mem_bridge: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  state_t              r_state;
  logic                r_is_wr;
  logic [FRAME_W-1:0]  r_frame;
  logic [BYTE_W-1:0]   r_byte_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [DATA_W-1:0]   r_rd_hold;
  logic                r_busy;
  logic                r_mem_done;
  logic                r_mem_err;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_tx_start;
  logic                w_tx_busy;
  logic                w_rx_valid;
  logic [7:0]          w_rx_byte;
  logic [DATA_W-1:0]   w_hold_next;

  assign busy     = r_busy;
  assign mem_done = r_mem_done;
  assign mem_err  = r_mem_err;
  assign rd_data  = r_rd_data;

  assign w_tx_start  = (r_state == SEND) && !w_tx_busy && (r_byte_cnt != '0);
  // Read bytes arrive LSB-first, so each new byte enters at the top and slides down.
  assign w_hold_next = (r_rd_hold >> 8) | (DATA_W'(w_rx_byte) << (DATA_W - 8));

  uart_byte_phy #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_tx_start (w_tx_start),
    .i_tx_byte  (r_frame[7:0]),
    .o_tx_busy  (w_tx_busy),
    .o_tx       (tx),
    .i_rx       (rx),
    .o_rx_valid (w_rx_valid),
    .o_rx_byte  (w_rx_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_is_wr    <= 1'b0;
      r_frame    <= '0;
      r_byte_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_rd_hold  <= '0;
      r_busy     <= 1'b0;
      r_mem_done <= 1'b0;
      r_mem_err  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_mem_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_we || req_re) begin
            r_is_wr    <= req_we;
            r_frame    <= {req_wdata, req_addr, (req_we ? CMD_WR : CMD_RD)};
            r_byte_cnt <= req_we ? WR_BYTES : RD_BYTES;
            r_rd_hold  <= '0;
            r_busy     <= 1'b1;
            r_mem_err  <= 1'b0;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (w_tx_start) begin
            r_frame    <= r_frame >> 8;
            r_byte_cnt <= r_byte_cnt - BYTE_W'(1);
          end else if (r_byte_cnt == '0 && !w_tx_busy) begin
            r_byte_cnt <= r_is_wr ? BYTE_W'(1) : RD_RESP;
            r_tmo_cnt  <= TMO_LAST;
            r_state    <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (w_rx_valid) begin
            r_tmo_cnt <= TMO_LAST;
            if (r_is_wr) begin
              r_state    <= DONE;
              r_busy     <= 1'b0;
              r_mem_done <= 1'b1;
              r_mem_err  <= (w_rx_byte != ACK_BYTE);
            end else begin
              r_rd_hold  <= w_hold_next;
              r_byte_cnt <= r_byte_cnt - BYTE_W'(1);
              if (r_byte_cnt == BYTE_W'(1)) begin
                r_state    <= DONE;
                r_busy     <= 1'b0;
                r_mem_done <= 1'b1;
                r_mem_err  <= 1'b0;
                r_rd_data  <= w_hold_next;
              end
            end
          end else if (r_tmo_cnt == '0) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_mem_done <= 1'b1;
            r_mem_err  <= 1'b1;
            if (!r_is_wr) r_rd_data <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge with a host-side UART model.
module tb_uart_mem_bridge;

  localparam int CPB     = 4;
  localparam int TMO     = 200;
  localparam int BYTE_CY = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        tx;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        req_re;
  logic        busy;
  logic        mem_done;
  logic        mem_err;
  logic [31:0] rd_data;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_mem_bridge #(
    .ADDR_W(32), .DATA_W(32), .CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_re(req_re),
    .busy(busy), .mem_done(mem_done), .mem_err(mem_err), .rd_data(rd_data)
  );

  // mode: 0 plain reply, 1 bad-stop byte before reply, 2 no reply, 3 toggle req_re while busy
  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          n_tx;
    logic [71:0] frame;
    int          n_rx;
    logic [31:0] reply;
    int          mode;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic get_tx_byte(output logic [7:0] b, output int ts, output bit ok);
    ok = 1'b0;
    b  = '0;
    ts = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    ts = cyc;
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    check("tx_stop_bit", tx, 1);
  endtask

  task automatic send_rx_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    if (!stop) begin
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [7:0] b;
    int t0, ts, tprev;
    bit ok;
    bit seen;
    t0 = 0;
    tprev = 0;
    @(negedge clk);
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_we    = v.we;
    req_re    = v.re;
    if (v.mode == 3) begin
      fork
        begin
          repeat (100) begin
            @(negedge clk);
            req_re = ~req_re;
          end
          req_re = 1'b1;
        end
      join_none
    end
    for (int i = 0; i < v.n_tx; i++) begin
      get_tx_byte(b, ts, ok);
      check({nm, "_tx_seen"}, ok, 1);
      if (!ok) begin
        req_we = 1'b0;
        req_re = 1'b0;
        return;
      end
      check({nm, "_tx_byte"}, b, v.frame[8*i +: 8]);
      if (i == 0) t0 = ts;
      else check({nm, "_tx_gap"}, ts - tprev, BYTE_CY);
      tprev = ts;
    end
    repeat (4) @(negedge clk);
    if (v.mode == 1) send_rx_byte(~v.reply[7:0], 1'b0);
    if (v.mode != 2) begin
      for (int i = 0; i < v.n_rx; i++) send_rx_byte(v.reply[8*i +: 8], 1'b1);
    end
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (mem_done) seen = 1'b1;
      else @(negedge clk);
    end
    check({nm, "_done_seen"}, seen, 1);
    if (v.mode == 2) check({nm, "_timeout_cycles"}, cyc - t0, v.n_tx * BYTE_CY + TMO);
    check({nm, "_busy_at_done"}, busy, 0);
    check({nm, "_mem_err"}, mem_err, v.exp_err);
    check({nm, "_rd_data"}, rd_data, v.exp_rd);
    req_we = 1'b0;
    req_re = 1'b0;
    @(negedge clk);
    check({nm, "_done_pulse_len"}, mem_done, 0);
    if (v.mode == 3) begin
      seen = 1'b0;
      repeat (60) begin
        @(negedge clk);
        if (!tx || busy) seen = 1'b1;
      end
      check({nm, "_no_second_frame"}, seen, 0);
    end
  endtask

  initial begin
    logic [7:0] b;
    int ts;
    bit ok;
    bit stray;

    vecs[0] = '{we:1, re:0, addr:32'h10, wdata:32'hDEADBEEF, n_tx:9,
                frame:72'hDEADBEEF_00000010_A5, n_rx:1, reply:32'h06, mode:0,
                exp_err:0, exp_rd:32'h0};
    vecs[1] = '{we:0, re:1, addr:32'h4, wdata:32'h0, n_tx:5,
                frame:72'h00000004_5A, n_rx:4, reply:32'h12345678, mode:0,
                exp_err:0, exp_rd:32'h12345678};
    vecs[2] = '{we:1, re:0, addr:32'h20, wdata:32'h01020304, n_tx:9,
                frame:72'h01020304_00000020_A5, n_rx:1, reply:32'h15, mode:0,
                exp_err:1, exp_rd:32'h12345678};
    vecs[3] = '{we:0, re:1, addr:32'h8, wdata:32'h0, n_tx:5,
                frame:72'h00000008_5A, n_rx:4, reply:32'h44332211, mode:1,
                exp_err:0, exp_rd:32'h44332211};
    vecs[4] = '{we:1, re:1, addr:32'h30, wdata:32'hCAFEF00D, n_tx:9,
                frame:72'hCAFEF00D_00000030_A5, n_rx:1, reply:32'h06, mode:3,
                exp_err:0, exp_rd:32'h44332211};
    vecs[5] = '{we:0, re:1, addr:32'hC, wdata:32'h0, n_tx:5,
                frame:72'h0000000C_5A, n_rx:0, reply:32'h0, mode:2,
                exp_err:1, exp_rd:32'h0};

    reset     = 1'b1;
    rx        = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    req_we    = 1'b0;
    req_re    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_mem_done", mem_done, 0);
    check("reset_mem_err", mem_err, 0);
    check("reset_rd_data", rd_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset lands in the middle of the third request byte.
    @(negedge clk);
    req_addr = 32'h40;
    req_re   = 1'b1;
    get_tx_byte(b, ts, ok);
    check("rst_byte0", b, 8'h5A);
    get_tx_byte(b, ts, ok);
    check("rst_byte1", b, 8'h40);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (!tx) ok = 1'b1;
    end
    check("rst_third_start_seen", ok, 1);
    repeat (5) @(negedge clk);
    reset  = 1'b1;
    req_re = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    reset = 1'b0;
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!tx || busy) stray = 1'b1;
    end
    check("rst_quiet_after", stray, 0);
    run_vec(vecs[1], "post_reset_read");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
